// File: rtl/simd_pkg.sv
// Shared SIMD definitions: lane width, writeback entry layout and ALU op encodings.
// Used by the writeback queue and the issue stage.
package simd_pkg;

  localparam int LANE_W = 32;

  // Default slice geometry; the writeback entry is laid out {rd, mask, data}, MSB first.
  localparam int WB_LANES  = 4;
  localparam int WB_REG_AW = 5;

  typedef struct packed {
    logic [WB_REG_AW-1:0]       rd;
    logic [WB_LANES-1:0]        mask;
    logic [WB_LANES*LANE_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    MUL = 2'b01
  } alu_op_e;

endpackage

// File: rtl/simd_sync_fifo.sv
// Generic register-array FIFO with push/pop/count. The head is held in an output
// register that is refreshed from next-state pointers, so it holds its last value when empty.
module simd_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic [AW-1:0]    w_rd_ptr_next;
  logic [AW:0]      w_count_next;

  assign w_pop = i_pop && (r_count != '0);

  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + AW'(1);
    end
    w_count_next = r_count;
    if (i_push && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!i_push && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      // The new head is the entry being written now when the queue was empty, or held one entry being popped.
      if (w_count_next != '0) begin
        if (i_push && (r_wr_ptr == w_rd_ptr_next)) begin
          r_dout <= i_din;
        end else begin
          r_dout <= r_mem[w_rd_ptr_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(i_push && !w_pop && (r_count == FULL)));
    end
  end

  assign o_dout  = r_dout;
  assign o_count = r_count;

endmodule

// File: rtl/simd_wb_queue.sv
// Writeback stage behind the SIMD ALU: tags each issued op, captures the ALU result one
// cycle later into a FIFO, and drains it to the register file with credit-based issue backpressure.
module simd_wb_queue
  import simd_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LANES-1:0]          issue_mask,
  input  logic [LANE_W*LANES-1:0]   alu_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_AW-1:0]         wb_rd,
  output logic [LANES-1:0]          wb_mask,
  output logic [LANE_W*LANES-1:0]   wb_data,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = LANE_W * LANES;
  localparam int EW = REG_AW + LANES + DW;

  logic              r_pend_v;
  logic [REG_AW-1:0] r_pend_rd;
  logic [LANES-1:0]  r_pend_mask;

  logic              w_fire;
  logic              w_pop;
  logic [EW-1:0]     w_din;
  logic [EW-1:0]     w_dout;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_credit_used;

  // Credits count both stored entries and the op still in flight through the ALU.
  assign w_credit_used = w_count + CW'(r_pend_v);
  assign issue_ready   = !reset && (w_credit_used < CW'(DEPTH));
  assign w_fire        = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_v    <= 1'b0;
      r_pend_rd   <= '0;
      r_pend_mask <= '0;
    end else begin
      r_pend_v <= w_fire;
      if (w_fire) begin
        r_pend_rd   <= issue_rd;
        r_pend_mask <= issue_mask;
      end
    end
  end

  assign w_din    = {r_pend_rd, r_pend_mask, alu_result};
  assign wb_valid = (w_count != '0);
  assign w_pop    = wb_valid && wb_ready;

  simd_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_pend_v),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_count (w_count)
  );

  assign wb_rd     = w_dout[EW-1 -: REG_AW];
  assign wb_mask   = w_dout[DW +: LANES];
  assign wb_data   = w_dout[DW-1:0];
  assign occupancy = w_count;

endmodule

// File: tb/tb_simd_wb_queue.sv
// Self-checking bench for simd_wb_queue: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
module tb_simd_wb_queue;

  localparam int LANES  = 4;
  localparam int DEPTH  = 4;
  localparam int REG_AW = 5;
  localparam int W      = 32 * LANES;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_ready;
  logic [REG_AW-1:0] issue_rd;
  logic [LANES-1:0]  issue_mask;
  logic [W-1:0]      alu_result;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_rd;
  logic [LANES-1:0]  wb_mask;
  logic [W-1:0]      wb_data;
  logic [$clog2(DEPTH):0] occupancy;

  simd_wb_queue #(.LANES(LANES), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rd    (issue_rd),
    .issue_mask  (issue_mask),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_mask     (wb_mask),
    .wb_data     (wb_data),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [LANES-1:0]  mask;
    logic [W-1:0]      data;
  } ent_t;

  ent_t              m_q[$];
  bit                m_pend_v;
  logic [REG_AW-1:0] m_pend_rd;
  logic [LANES-1:0]  m_pend_mask;

  int errors = 0;
  int checks = 0;

  function automatic bit model_ready();
    return !reset && ((m_q.size() + (m_pend_v ? 1 : 0)) < DEPTH);
  endfunction

  // Advance one clock: the model applies the transaction rules to the inputs present at the edge.
  task automatic tick();
    bit fire, pop;
    logic [W-1:0] res;
    ent_t e;
    fire = issue_valid && model_ready();
    pop  = (m_q.size() != 0) && wb_ready;
    res  = alu_result;
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_pend_v = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_pend_v) begin
        e.rd = m_pend_rd; e.mask = m_pend_mask; e.data = res;
        m_q.push_back(e);
      end
      m_pend_v = fire;
      if (fire) begin
        m_pend_rd = issue_rd;
        m_pend_mask = issue_mask;
      end
    end
    #2;
    alu_result = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1; issue_valid = 1; issue_rd = 5'd7; issue_mask = 4'hF; wb_ready = 1;
    repeat (3) tick();
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready got=%0b exp=0", issue_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    checks++; if (occupancy !== 0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (wb_rd !== 0 || wb_mask !== 0) begin errors++; $display("FAIL reset_wb_rd_mask got=%0h/%0h exp=0/0", wb_rd, wb_mask); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got=%0h exp=0", wb_data); end
    issue_valid = 0; reset = 0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", issue_ready); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_release_idle got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_single();
    logic [W-1:0] exp_data;
    exp_data = {32'd4, 32'd3, 32'd2, 32'd1};
    issue_valid = 1; issue_rd = 5'd3; issue_mask = 4'hF; wb_ready = 1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%0b exp=1", issue_ready); end
    tick();
    issue_valid = 0;
    alu_result = exp_data;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b exp=0", wb_valid); end
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_mask !== 4'hF) begin
      errors++; $display("FAIL single_head got=v%0b rd%0d m%0h exp=v1 rd3 mF", wb_valid, wb_rd, wb_mask); end
    checks++; if (wb_data !== exp_data) begin errors++; $display("FAIL single_data got=%0h exp=%0h", wb_data, exp_data); end
    checks++; if (occupancy !== 1) begin errors++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    tick();
    checks++; if (occupancy !== 0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL single_drained got=occ%0d v%0b exp=occ0 v0", occupancy, wb_valid); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    wb_ready = 0; issue_valid = 1; issue_mask = 4'hA;
    for (int c = 0; c < 8; c++) begin
      issue_rd = REG_AW'(accepted + 1);
      #1;
      checks++; if (issue_ready !== model_ready()) begin
        errors++; $display("FAIL bp_ready cyc=%0d got=%0b exp=%0b", c, issue_ready, model_ready()); end
      if (issue_ready) accepted++;
      tick();
      checks++; if (occupancy !== m_q.size()) begin
        errors++; $display("FAIL bp_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_q.size()); end
    end
    issue_valid = 0;
    checks++; if (accepted !== 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", accepted); end
    checks++; if (issue_ready !== 1'b0 || occupancy !== 4) begin
      errors++; $display("FAIL bp_full got=rdy%0b occ%0d exp=rdy0 occ4", issue_ready, occupancy); end
  endtask

  task automatic test_drain();
    wb_ready = 1; issue_valid = 0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL drain_ready_pre got=%0b exp=0", issue_ready); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (wb_valid !== 1'b1 || wb_rd !== REG_AW'(k)) begin
        errors++; $display("FAIL drain_order k=%0d got=v%0b rd%0d exp=v1 rd%0d", k, wb_valid, wb_rd, k); end
      checks++; if (m_q.size() == 0 || wb_data !== m_q[0].data) begin
        errors++; $display("FAIL drain_data k=%0d got=%0h", k, wb_data); end
      tick();
      if (k == 1) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_post got=%0b exp=1", issue_ready); end
      end
    end
    checks++; if (occupancy !== 0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty got=occ%0d v%0b exp=occ0 v0", occupancy, wb_valid); end
  endtask

  task automatic test_simul();
    logic [W-1:0] b_data;
    wb_ready = 0; issue_valid = 1; issue_rd = 5'd10; issue_mask = 4'h3;
    tick();
    issue_rd = 5'd11; issue_mask = 4'hC;
    tick();
    issue_valid = 0; wb_ready = 1;
    b_data = alu_result;
    checks++; if (occupancy !== 1 || wb_rd !== 5'd10) begin
      errors++; $display("FAIL simul_pre got=occ%0d rd%0d exp=occ1 rd10", occupancy, wb_rd); end
    tick();
    checks++; if (occupancy !== 1) begin errors++; $display("FAIL simul_occ got=%0d exp=1", occupancy); end
    checks++; if (wb_rd !== 5'd11 || wb_mask !== 4'hC || wb_data !== b_data) begin
      errors++; $display("FAIL simul_new_head got=rd%0d m%0h d%0h exp=rd11 mC d%0h", wb_rd, wb_mask, wb_data, b_data); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL simul_drained got=%0b exp=0", wb_valid); end
  endtask

  task automatic test_mask_wrap();
    logic [LANES-1:0] masks[3];
    int n_issued = 0;
    int zero_pops = 0;
    int cyc = 0;
    masks[0] = 4'h0; masks[1] = 4'h5; masks[2] = 4'hF;
    while ((n_issued < 10 || m_q.size() != 0 || m_pend_v) && cyc < 300) begin
      issue_valid = (n_issued < 10) && ($urandom_range(0, 3) != 0);
      issue_rd    = REG_AW'($urandom_range(0, 31));
      issue_mask  = masks[n_issued % 3];
      wb_ready    = $urandom_range(0, 1) != 0;
      #1;
      checks++; if (issue_ready !== model_ready()) begin
        errors++; $display("FAIL mw_ready cyc=%0d got=%0b exp=%0b", cyc, issue_ready, model_ready()); end
      if (issue_valid && issue_ready) n_issued++;
      if (wb_valid && wb_ready && wb_mask == 4'h0) zero_pops++;
      tick();
      cyc++;
      checks++; if (wb_valid !== (m_q.size() != 0) || occupancy !== m_q.size()) begin
        errors++; $display("FAIL mw_state cyc=%0d got=v%0b occ%0d exp=occ%0d", cyc, wb_valid, occupancy, m_q.size()); end
      if (m_q.size() != 0) begin
        checks++; if (wb_rd !== m_q[0].rd || wb_mask !== m_q[0].mask || wb_data !== m_q[0].data) begin
          errors++; $display("FAIL mw_head cyc=%0d got=rd%0d m%0h exp=rd%0d m%0h", cyc, wb_rd, wb_mask, m_q[0].rd, m_q[0].mask); end
      end
    end
    checks++; if (n_issued != 10 || m_q.size() != 0 || cyc >= 300) begin
      errors++; $display("FAIL mw_complete got=issued%0d left%0d cyc%0d exp=issued10 left0", n_issued, m_q.size(), cyc); end
    checks++; if (zero_pops != 4) begin errors++; $display("FAIL mw_zero_mask_pops got=%0d exp=4", zero_pops); end
    wb_ready = 1; issue_valid = 0;
  endtask

  task automatic test_reset_mid();
    wb_ready = 0; issue_valid = 1; issue_mask = 4'h9;
    for (int k = 0; k < 4; k++) begin
      issue_rd = REG_AW'(20 + k);
      tick();
    end
    issue_valid = 0;
    checks++; if (occupancy !== 3 || !m_pend_v) begin
      errors++; $display("FAIL rm_setup got=occ%0d exp=occ3", occupancy); end
    reset = 1;
    tick();
    checks++; if (wb_valid !== 1'b0 || occupancy !== 0 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL rm_cleared got=v%0b occ%0d rdy%0b exp=v0 occ0 rdy0", wb_valid, occupancy, issue_ready); end
    reset = 0; wb_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (wb_valid !== 1'b0 || occupancy !== 0) begin
        errors++; $display("FAIL rm_stale cyc=%0d got=v%0b occ%0d exp=v0 occ0", k, wb_valid, occupancy); end
    end
  endtask

  initial begin
    reset = 1; issue_valid = 0; issue_rd = '0; issue_mask = '0; wb_ready = 0; alu_result = '0;
    m_pend_v = 0; m_pend_rd = '0; m_pend_mask = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_drain();
    test_simul();
    test_mask_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_wb_queue.md
# simd_wb_queue

Writeback stage directly downstream of the SIMD ALU. It tracks each operation issued to the ALU, captures the ALU's registered result one cycle later, and buffers the result with its destination register and lane mask in a small FIFO. The FIFO drains to the vector register file write port over a valid/ready handshake. Issue backpressure is credit-based, so the stall-free, fixed-latency ALU can never overrun the FIFO.

## Interface
Parameters:
- LANES, 4: number of 32-bit lanes; must match the ALU.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- REG_AW, 5: destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- issue_valid  in  1  upstream presents an ALU op this cycle
- issue_ready  out  1  op may be issued; issue fires on valid&&ready
- issue_rd  in  REG_AW  destination register of issued op
- issue_mask  in  LANES  per-lane write enable of issued op
- alu_result  in  32*LANES  ALU registered result, lane i at [i*32 +: 32]
- wb_valid  out  1  head entry available
- wb_ready  in  1  register file accepts head entry
- wb_rd  out  REG_AW  head destination register
- wb_mask  out  LANES  head lane mask
- wb_data  out  32*LANES  head result data
- occupancy  out  $clog2(DEPTH)+1  entries currently stored

## Operation
- Tag stage: on issue fire in cycle N, register {rd, mask} into a one-deep pending slot (pend_v=1). If there is no fire in cycle N, pend_v=0 at N+1.
- Capture: in cycle N+1, while pend_v=1, push {pend_rd, pend_mask, alu_result} into the FIFO. The ALU result for an op issued at N is valid exactly during N+1.
- Credit: issue_ready = !reset && (count + pend_v) < DEPTH.
  - Computed from registered state only.
  - No combinational path from wb_ready or issue_valid.
  - A pop in the current cycle does not free a credit until the next cycle.
- Drain: wb_valid = (count != 0). wb_rd, wb_mask and wb_data show the head entry. On wb_valid && wb_ready, pop the head.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the data stays consistent. When count==1, the popped entry is the old head; the pushed entry becomes the new head next cycle.
- Full: count==DEPTH is reachable only if no pending slot is outstanding. The credit rule guarantees a push never occurs when count==DEPTH without a simultaneous pop. An overflow is an assertion failure.
- Empty: wb_valid=0. wb_* data holds the last value and carries no meaning.
- Zero mask: an entry with mask==0 is queued and drained like any other. The register file ignores it.
- Pointers wrap modulo DEPTH. Count is a separate register of $clog2(DEPTH)+1 bits.
- alu_result is not sampled when pend_v=0.

## Timing
- Reset values:
  - pend_v=0, count=0, read and write pointers = 0.
  - wb_valid=0, occupancy=0.
  - issue_ready=0 while reset is high, and 1 in the first cycle after it drops.
  - wb_rd, wb_mask and wb_data are 0.
- Latency: issue fires at N → entry pushed at the N+1 edge → wb_valid=1 during N+2, provided the queue was empty. Minimum issue-to-writeback is 2 cycles.
- Throughput: one issue and one writeback per cycle sustained when wb_ready stays high.
- After a stall, throughput is limited to DEPTH-1 back-to-back issues until a pop registers.
- Reset mid-operation: the pending op and all queued entries are discarded. The ALU's own reset clears its result in the same cycle.
- occupancy is registered and equals count.

## Structure
- Shared package simd_pkg holds:
  - LANE_W=32.
  - The typedef wb_entry_t {rd, mask, data}, parameterised by LANES and REG_AW via localparams.
  - The ALU op encodings ADD=2'b00 and MUL=2'b01, shared with the issue stage.
- Sub-module: simd_sync_fifo, a generic DEPTH×width register-array FIFO with push/pop/count and no first-word fall-through. It is instantiated once. Credit and pending logic stay in the top module.

## Test plan
- Single op: issue rd=3, mask=4'b1111 at N, with ALU result lanes {1,2,3,4} at N+1 and wb_ready=1 → wb_valid high exactly in N+2 with rd=3 and data {1,2,3,4}; occupancy returns to 0 at N+3.
- Backpressure: wb_ready=0, issue every cycle → exactly 4 issues accepted (pend plus 3 queued, then a 4th push) and issue_ready=0 afterwards; occupancy=4; no overflow.
- Drain order: after the fill above, set wb_ready=1 → rd values pop in issue order (e.g. 1,2,3,4) on consecutive cycles, and issue_ready reasserts one cycle after the first pop.
- Simultaneous push and pop at count=1: occupancy stays 1, the popped entry is the older one, and the new entry appears next cycle.
- Mask and wrap: issue 10 ops with masks cycling 0000, 0101, 1111 under random wb_ready → all 10 drain in order with correct masks, including mask 0000, and the pointers wrap.
- Reset mid-stream: assert reset with occupancy=3 and pend_v=1 → next cycle wb_valid=0, occupancy=0, and no stale entry appears after release.
